branch_resolver: RTL and testbench
==================================

# branch_resolver

Sequential branch-resolution stage for the MIPS core. It consumes decoded branch requests from ID and evaluates the branch condition on the register operands: beq, bne, bgez, bgtz, blez, bltz and j. It computes the target and drives a one-cycle redirect (plus optional flush) toward the fetch/PC logic. Operand hazards are handled by holding the request and stalling until forwarded operands are ready.

## Interface
- No parameters; widths are fixed at 32-bit data and 16-bit immediate.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- br_valid  input  1  branch request present
- br_ready  output  1  request accepted when br_valid && br_ready
- br_op  input  3  000 beq, 001 bne, 010 bgez, 011 bgtz, 100 blez, 101 bltz, 110 j, 111 reserved
- pc  input  32  address of the branch instruction
- imm16  input  16  branch offset in words
- rs_data  input  32  operand rs, signed
- rt_data  input  32  operand rt
- operands_ready  input  1  rs_data/rt_data are valid this cycle
- stall  output  1  upstream must hold ID
- redirect_valid  output  1  one-cycle pulse: load redirect_pc
- redirect_pc  output  32  branch target
- flush  output  1  one-cycle pulse: kill the instruction fetched after the branch
- taken_count  output  32  saturating count of taken branches

## Operation
- States: IDLE, WAIT, RESOLVE.
- IDLE:
  - br_ready=1.
  - On accept, capture br_op, pc and imm16.
  - If operands_ready, evaluate immediately and go to RESOLVE.
  - Otherwise go to WAIT.
- WAIT:
  - br_ready=0, stall=1.
  - rs_data/rt_data are re-sampled every cycle.
  - When operands_ready=1, evaluate and go to RESOLVE.
- RESOLVE: lasts one cycle.
  - br_ready=0.
  - If taken: redirect_valid=1 and redirect_pc=target.
  - Always returns to IDLE.
- Conditions: rs is signed two's complement.
  - beq: rs==rt; bne: rs!=rt.
  - bgez: rs>=0; bgtz: rs>0; blez: rs<=0; bltz: rs<0.
  - j: always taken.
  - 111: never taken, no error.
- Target: pc + 4 + (sign_extend(imm16) << 2), computed modulo 2^32 (wraps silently).
- taken_count:
  - Increments in the cycle redirect_valid is asserted.
  - Saturates at 0xFFFFFFFF.
- Not-taken: redirect_valid=0, flush=0, redirect_pc holds its previous value.
- Reset: rst=1 at any edge, including mid-WAIT or mid-RESOLVE, forces IDLE.
  - Drops any pending request.
  - Reset values: br_ready=1 after release, stall=0, redirect_valid=0, flush=0, redirect_pc=0, taken_count=0.

## Timing
- Resolution latency:
  - Evaluation happens on the accept edge when operands_ready=1.
  - redirect_valid is high the following cycle, registered from RESOLVE.
  - Accept-to-redirect is exactly 1 cycle with operands ready.
  - It is 1 + N cycles with N cycles of WAIT.
- stall is combinational from state: high throughout WAIT, low otherwise.
- Back-to-back throughput is one branch per 2 cycles; br_ready is low in RESOLVE.
- br_valid asserted while br_ready=0 is ignored; upstream holds it.
- operands_ready rising in the same cycle as the WAIT entry edge is not seen until the next cycle.
- All outputs are registered or decoded from state; there is no combinational input-to-output path.

## Configuration
- BRANCH_DELAY_SLOT_EN
- Defined (MIPS delay-slot semantics):
  - flush is tied to 0.
  - The instruction after the branch always completes.
  - The redirect is a pure PC load.
- Undefined:
  - flush pulses for exactly one cycle, coincident with each taken redirect_valid.
  - It is not asserted for not-taken branches.

## Test plan
- bgez at pc=0x00400000, imm16=0x0004, rs=0, operands_ready=1 -> next cycle redirect_valid=1, redirect_pc=0x00400014, taken_count=1.
- bgtz, rs=0 -> no redirect; bltz, rs=0x80000000 -> taken. blez, rs=0xFFFFFFFF -> taken; bne, rs=rt=5 -> not taken.
- beq, imm16=0xFFFF, pc=0x00400010, rs=rt -> redirect_pc=0x00400010. Backward wrap: pc=0x00000000, imm16=0x8000 -> redirect_pc=0xFFFE0004.
- operands_ready low 3 cycles after accept -> stall=1 for 3 cycles, br_ready=0, redirect exactly 1 cycle after operands_ready rises, condition computed on final rs/rt.
- rst asserted during WAIT -> next cycle IDLE, stall=0, no redirect ever issued, taken_count=0.
- Flush and saturation:
  - Without BRANCH_DELAY_SLOT_EN, a taken j -> flush=1 in the same cycle as redirect_valid. With the macro, flush stays 0.
  - taken_count forced near 0xFFFFFFFF -> stays at 0xFFFFFFFF on further taken branches.

Source files
------------

// File: rtl/branch_resolver_if.sv
// Branch request / redirect bundle between ID, the branch resolver and the
// fetch/PC logic. The master modport is the ID-side producer of requests.
interface branch_resolver_if;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_op;
  logic [31:0] pc;
  logic [15:0] imm16;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        operands_ready;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] taken_count;

  modport master (
    output br_valid, br_op, pc, imm16, rs_data, rt_data, operands_ready,
    input  br_ready, stall, redirect_valid, redirect_pc, flush, taken_count
  );

  modport slave (
    input  br_valid, br_op, pc, imm16, rs_data, rt_data, operands_ready,
    output br_ready, stall, redirect_valid, redirect_pc, flush, taken_count
  );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolution stage: accepts a decoded branch from ID, waits for the
// operands if needed, evaluates the condition and issues a one-cycle redirect.
// Optional macro BRANCH_DELAY_SLOT_EN: when defined, flush is tied low
// (MIPS delay-slot semantics); when undefined, flush accompanies each redirect.
module branch_resolver (
  input logic               clk,
  input logic               rst,
  branch_resolver_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESOLVE
  } state_t;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BGEZ = 3'b010;
  localparam logic [2:0] OP_BGTZ = 3'b011;
  localparam logic [2:0] OP_BLEZ = 3'b100;
  localparam logic [2:0] OP_BLTZ = 3'b101;
  localparam logic [2:0] OP_J    = 3'b110;

  state_t      r_state;
  state_t      w_nextState;

  logic [2:0]  r_op;
  logic [31:0] r_pc;
  logic [15:0] r_imm;
  logic        r_taken;
  logic [31:0] r_redirectPc;
  logic [31:0] r_takenCount;

  logic        w_accept;
  logic        w_evaluate;
  logic [2:0]  w_evalOp;
  logic [31:0] w_evalPc;
  logic [15:0] w_evalImm;
  logic        w_cond;
  logic [31:0] w_target;

  // A request is only taken in IDLE; evaluation happens either on that same
  // accept edge (operands ready) or on the first WAIT cycle that sees them.
  assign w_accept   = bus.br_valid && (r_state == S_IDLE);
  assign w_evaluate = (w_accept && bus.operands_ready) ||
                      ((r_state == S_WAIT) && bus.operands_ready);

  // On the accept edge the captured fields are not loaded yet, so use the
  // live request; in WAIT use the held copy.
  assign w_evalOp  = (r_state == S_IDLE) ? bus.br_op : r_op;
  assign w_evalPc  = (r_state == S_IDLE) ? bus.pc    : r_pc;
  assign w_evalImm = (r_state == S_IDLE) ? bus.imm16 : r_imm;

  // Word offset sign-extended and scaled; the add wraps modulo 2^32.
  assign w_target = w_evalPc + 32'd4 + {{14{w_evalImm[15]}}, w_evalImm, 2'b00};

  // Branch condition on the current operands, rs treated as signed.
  always_comb begin
    w_cond = 1'b0;
    case (w_evalOp)
      OP_BEQ:  w_cond = (bus.rs_data == bus.rt_data);
      OP_BNE:  w_cond = (bus.rs_data != bus.rt_data);
      OP_BGEZ: w_cond = ($signed(bus.rs_data) >= 32'sd0);
      OP_BGTZ: w_cond = ($signed(bus.rs_data) >  32'sd0);
      OP_BLEZ: w_cond = ($signed(bus.rs_data) <= 32'sd0);
      OP_BLTZ: w_cond = ($signed(bus.rs_data) <  32'sd0);
      OP_J:    w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  // State register; reset at any point drops a pending request.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic: RESOLVE always lasts exactly one cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_nextState = bus.operands_ready ? S_RESOLVE : S_WAIT;
      end
      S_WAIT: begin
        if (bus.operands_ready) w_nextState = S_RESOLVE;
      end
      S_RESOLVE: w_nextState = S_IDLE;
      default:   w_nextState = S_IDLE;
    endcase
  end

  // Request capture, outcome/target registers and the saturating counter.
  // The count and target update on the evaluation edge so they become
  // visible in the same cycle as redirect_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op         <= 3'b000;
      r_pc         <= 32'd0;
      r_imm        <= 16'd0;
      r_taken      <= 1'b0;
      r_redirectPc <= 32'd0;
      r_takenCount <= 32'd0;
    end else begin
      if (w_accept) begin
        r_op  <= bus.br_op;
        r_pc  <= bus.pc;
        r_imm <= bus.imm16;
      end
      if (w_evaluate) begin
        r_taken <= w_cond;
        if (w_cond) begin
          r_redirectPc <= w_target;
          if (r_takenCount != 32'hFFFF_FFFF) r_takenCount <= r_takenCount + 32'd1;
        end
      end
    end
  end

  // Outputs decoded from state and registers only.
  always_comb begin
    bus.br_ready       = (r_state == S_IDLE);
    bus.stall          = (r_state == S_WAIT);
    bus.redirect_valid = (r_state == S_RESOLVE) && r_taken;
    bus.redirect_pc    = r_redirectPc;
    bus.taken_count    = r_takenCount;
`ifdef BRANCH_DELAY_SLOT_EN
    bus.flush          = 1'b0;
`else
    bus.flush          = (r_state == S_RESOLVE) && r_taken;
`endif
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: a table of single-branch vectors
// plus hand-written WAIT, reset-during-WAIT and counter saturation sequences.
module tb_branch_resolver;

  logic clk = 1'b0;
  logic rst = 1'b1;

  branch_resolver_if bus ();

  branch_resolver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] pc;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        expTaken;
    logic [31:0] expPc;
  } vec_t;

  vec_t        vecs [14];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] expRedirectPc = 32'd0;
  logic [31:0] expCount      = 32'd0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic expFlush(input logic taken);
`ifdef BRANCH_DELAY_SLOT_EN
    return 1'b0;
`else
    return taken;
`endif
  endfunction

  task automatic idleInputs();
    bus.br_valid       = 1'b0;
    bus.br_op          = 3'b000;
    bus.pc             = 32'd0;
    bus.imm16          = 16'd0;
    bus.rs_data        = 32'd0;
    bus.rt_data        = 32'd0;
    bus.operands_ready = 1'b0;
  endtask

  // One branch with operands ready at accept; redirect is checked the cycle
  // after the accept edge, then the return to IDLE one cycle later.
  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    bus.br_valid       = 1'b1;
    bus.br_op          = v.op;
    bus.pc             = v.pc;
    bus.imm16          = v.imm;
    bus.rs_data        = v.rs;
    bus.rt_data        = v.rt;
    bus.operands_ready = 1'b1;
    @(negedge clk);
    if (v.expTaken) begin
      expRedirectPc = v.expPc;
      if (expCount != 32'hFFFF_FFFF) expCount = expCount + 32'd1;
    end
    checkOutput({tag, ".redirect_valid"}, {31'd0, bus.redirect_valid}, {31'd0, v.expTaken});
    checkOutput({tag, ".redirect_pc"}, bus.redirect_pc, expRedirectPc);
    checkOutput({tag, ".flush"}, {31'd0, bus.flush}, {31'd0, expFlush(v.expTaken)});
    checkOutput({tag, ".taken_count"}, bus.taken_count, expCount);
    checkOutput({tag, ".br_ready_resolve"}, {31'd0, bus.br_ready}, 32'd0);
    idleInputs();
    @(negedge clk);
    checkOutput({tag, ".br_ready_idle"}, {31'd0, bus.br_ready}, 32'd1);
    checkOutput({tag, ".redirect_valid_idle"}, {31'd0, bus.redirect_valid}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'b010, 32'h0040_0000, 16'h0004, 32'h0000_0000, 32'h0,         1'b1, 32'h0040_0014};
    vecs[1]  = '{3'b011, 32'h0040_0100, 16'h0004, 32'h0000_0000, 32'h0,         1'b0, 32'h0};
    vecs[2]  = '{3'b101, 32'h0000_1000, 16'h0010, 32'h8000_0000, 32'h0,         1'b1, 32'h0000_1044};
    vecs[3]  = '{3'b100, 32'h0000_2000, 16'h0000, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'h0000_2004};
    vecs[4]  = '{3'b001, 32'h0000_3000, 16'h0008, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0};
    vecs[5]  = '{3'b000, 32'h0040_0010, 16'hFFFF, 32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0040_0010};
    vecs[6]  = '{3'b110, 32'h0000_0000, 16'h8000, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFE_0004};
    vecs[7]  = '{3'b111, 32'h0000_4000, 16'h0004, 32'h0000_0003, 32'h0000_0003, 1'b0, 32'h0};
    vecs[8]  = '{3'b000, 32'h0000_5000, 16'h0004, 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0};
    vecs[9]  = '{3'b001, 32'h0000_0100, 16'h0001, 32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0108};
    vecs[10] = '{3'b011, 32'h0000_0300, 16'h0002, 32'h0000_0001, 32'h0,         1'b1, 32'h0000_030C};
    vecs[11] = '{3'b010, 32'h0000_0400, 16'h0002, 32'hFFFF_FFFF, 32'h0,         1'b0, 32'h0};
    vecs[12] = '{3'b100, 32'h0000_0500, 16'h0002, 32'h0000_0001, 32'h0,         1'b0, 32'h0};
    vecs[13] = '{3'b101, 32'h0000_0600, 16'h0002, 32'h0000_0000, 32'h0,         1'b0, 32'h0};

    idleInputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset.br_ready", {31'd0, bus.br_ready}, 32'd1);
    checkOutput("reset.stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("reset.redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    checkOutput("reset.flush", {31'd0, bus.flush}, 32'd0);
    checkOutput("reset.redirect_pc", bus.redirect_pc, 32'd0);
    checkOutput("reset.taken_count", bus.taken_count, 32'd0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Operands late by three cycles: beq whose rs/rt differ while waiting
    // but match on the cycle operands_ready rises.
    @(negedge clk);
    bus.br_valid       = 1'b1;
    bus.br_op          = 3'b000;
    bus.pc             = 32'h0000_0500;
    bus.imm16          = 16'h0003;
    bus.rs_data        = 32'h0000_0001;
    bus.rt_data        = 32'h0000_0002;
    bus.operands_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.br_valid = 1'b0;
      bus.pc       = 32'hDEAD_0000;
      bus.imm16    = 16'h1234;
      checkOutput($sformatf("wait%0d.stall", c), {31'd0, bus.stall}, 32'd1);
      checkOutput($sformatf("wait%0d.br_ready", c), {31'd0, bus.br_ready}, 32'd0);
      checkOutput($sformatf("wait%0d.redirect_valid", c), {31'd0, bus.redirect_valid}, 32'd0);
      bus.rs_data = 32'h0000_0010 + c;
      bus.rt_data = 32'h0000_0020 + c;
    end
    bus.rs_data        = 32'h0000_0009;
    bus.rt_data        = 32'h0000_0009;
    bus.operands_ready = 1'b1;
    @(negedge clk);
    expRedirectPc = 32'h0000_0510;
    expCount      = expCount + 32'd1;
    checkOutput("waitres.redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
    checkOutput("waitres.redirect_pc", bus.redirect_pc, expRedirectPc);
    checkOutput("waitres.flush", {31'd0, bus.flush}, {31'd0, expFlush(1'b1)});
    checkOutput("waitres.stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("waitres.taken_count", bus.taken_count, expCount);
    idleInputs();
    @(negedge clk);
    checkOutput("waitres.pulse_end", {31'd0, bus.redirect_valid}, 32'd0);

    // Reset while waiting on operands: the pending j must never redirect.
    @(negedge clk);
    bus.br_valid       = 1'b1;
    bus.br_op          = 3'b110;
    bus.pc             = 32'h0000_7000;
    bus.operands_ready = 1'b0;
    @(negedge clk);
    bus.br_valid = 1'b0;
    checkOutput("rstwait.stall_before", {31'd0, bus.stall}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.operands_ready = 1'b1;
    checkOutput("rstwait.stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("rstwait.br_ready", {31'd0, bus.br_ready}, 32'd1);
    expRedirectPc = 32'd0;
    expCount      = 32'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rstwait%0d.redirect_valid", c), {31'd0, bus.redirect_valid}, 32'd0);
      checkOutput($sformatf("rstwait%0d.taken_count", c), bus.taken_count, 32'd0);
    end
    checkOutput("rstwait.redirect_pc", bus.redirect_pc, 32'd0);
    idleInputs();

    // Saturation: preload the counter just below the ceiling.
    @(negedge clk);
    force dut.r_takenCount = 32'hFFFF_FFFE;
    #1;
    release dut.r_takenCount;
    expCount = 32'hFFFF_FFFE;
    applyStimulus('{3'b110, 32'h0000_8000, 16'h0001, 32'h0, 32'h0, 1'b1, 32'h0000_8008}, "sat1");
    applyStimulus('{3'b110, 32'h0000_9000, 16'h0002, 32'h0, 32'h0, 1'b1, 32'h0000_900C}, "sat2");
    checkOutput("sat.final", bus.taken_count, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
